// File: rtl/sign_narrow.sv
`default_nettype none
// ============================================================================
// Module      : sign_narrow
// Description : Narrows an M-bit two's-complement stream to N bits behind a
//               2-entry skid buffer, flagging values that do not fit.
//               Define SIGN_NARROW_SAT_EN to clamp overflowed beats.
// Revision    : 1.0 - initial release
// ============================================================================
module sign_narrow #(
    parameter int M  = 32,
    parameter int N  = 12,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [M-1:0]  i_x,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [N-1:0]  o_y,
    output logic          o_ovf,
    input  logic          i_clr,
    output logic          o_ovf_sticky,
    output logic [CW-1:0] o_ovf_cnt
);

    localparam logic [CW-1:0] c_cnt_max = {CW{1'b1}};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_valid;
    logic            r_ready;
    logic [N-1:0]    r_y;
    logic            r_ovf;
    logic [N-1:0]    r_skid_y;
    logic            r_skid_ovf;
    logic            r_sticky;
    logic [CW-1:0]   r_cnt;

    logic            w_acc;
    logic            w_drain;
    logic            w_ovf;
    logic [N-1:0]    w_y;
    logic [CW-1:0]   w_cnt_base;
    logic            w_sticky_base;

    assign w_acc   = i_valid & r_ready;
    assign w_drain = r_valid & i_ready;

    // The value fits when every bit from the N-bit sign position upward agrees.
    assign w_ovf = ~((&i_x[M-1:N-1]) | ~(|i_x[M-1:N-1]));

    always_comb begin
        w_y = i_x[N-1:0];
`ifdef SIGN_NARROW_SAT_EN
        if (w_ovf) begin
            w_y = {i_x[M-1], {(N-1){~i_x[M-1]}}};
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_EMPTY;
            r_valid    <= 1'b0;
            r_ready    <= 1'b0;
            r_y        <= '0;
            r_ovf      <= 1'b0;
            r_skid_y   <= '0;
            r_skid_ovf <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    r_ready <= 1'b1;
                    if (w_acc) begin
                        r_y     <= w_y;
                        r_ovf   <= w_ovf;
                        r_valid <= 1'b1;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_drain) begin
                        r_y   <= w_y;
                        r_ovf <= w_ovf;
                    end else if (w_acc) begin
                        r_skid_y   <= w_y;
                        r_skid_ovf <= w_ovf;
                        r_ready    <= 1'b0;
                        r_state    <= ST_TWO;
                    end else if (w_drain) begin
                        r_valid <= 1'b0;
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_drain) begin
                        r_y     <= r_skid_y;
                        r_ovf   <= r_skid_ovf;
                        r_ready <= 1'b1;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    // Clear takes effect before a same-cycle overflow is counted.
    always_comb begin
        w_cnt_base    = i_clr ? '0 : r_cnt;
        w_sticky_base = i_clr ? 1'b0 : r_sticky;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (w_acc && w_ovf) begin
            r_sticky <= 1'b1;
            r_cnt    <= (w_cnt_base == c_cnt_max) ? w_cnt_base : w_cnt_base + 1'b1;
        end else begin
            r_sticky <= w_sticky_base;
            r_cnt    <= w_cnt_base;
        end
    end

    assign o_ready      = r_ready;
    assign o_valid      = r_valid;
    assign o_y          = r_y;
    assign o_ovf        = r_ovf;
    assign o_ovf_sticky = r_sticky;
    assign o_ovf_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sign_narrow.sv
`default_nettype none
// ============================================================================
// Module      : tb_sign_narrow
// Description : Directed and randomised checks for sign_narrow (CW=4 instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sign_narrow;

    localparam int M  = 32;
    localparam int N  = 12;
    localparam int CW = 4;
    localparam int c_cnt_max = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [M-1:0]  i_x = '0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [N-1:0]  o_y;
    logic          o_ovf;
    logic          i_clr = 1'b0;
    logic          o_ovf_sticky;
    logic [CW-1:0] o_ovf_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    sign_narrow #(.M(M), .N(N), .CW(CW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_x          (i_x),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_y          (o_y),
        .o_ovf        (o_ovf),
        .i_clr        (i_clr),
        .o_ovf_sticky (o_ovf_sticky),
        .o_ovf_cnt    (o_ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: fit iff x lies in [-2^(N-1), 2^(N-1)-1].
    function automatic logic model_ovf(input logic [M-1:0] x);
        longint v;
        v = longint'($signed(x));
        return (v > ((64'sd1 <<< (N-1)) - 1)) || (v < -(64'sd1 <<< (N-1)));
    endfunction

    function automatic logic [N-1:0] model_y(input logic [M-1:0] x);
`ifdef SIGN_NARROW_SAT_EN
        if (model_ovf(x)) return x[M-1] ? (N'(1) << (N-1)) : ((N'(1) << (N-1)) - N'(1));
`endif
        return x[N-1:0];
    endfunction

    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b1; i_x = 32'h0000_0800; i_ready = 1'b1;
        tick(); tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", o_valid); end
        n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b want 0", o_ready); end
        n_checks++; if (o_y !== 12'h000 || o_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_data: got y=%h ovf=%0b want 000/0", o_y, o_ovf); end
        n_checks++; if (o_ovf_sticky !== 1'b0 || o_ovf_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_stats: got %0b/%0d want 0/0", o_ovf_sticky, o_ovf_cnt); end
        rst = 1'b0; i_valid = 1'b0;
        tick();
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %0b want 1", o_ready); end
    endtask

    task automatic test_narrow();
        logic [N-1:0] exp_y;
        i_ready = 1'b1; i_valid = 1'b1; i_x = 32'h0000_07FF;
        tick();
        n_checks++; if (o_valid !== 1'b1 || o_y !== 12'h7FF || o_ovf !== 1'b0) begin n_fail++; $display("FAIL narrow_7ff: got v=%0b y=%h ovf=%0b want 1/7ff/0", o_valid, o_y, o_ovf); end
        i_x = 32'hFFFF_F800;
        tick();
        n_checks++; if (o_y !== 12'h800 || o_ovf !== 1'b0 || o_ovf_cnt !== 4'd0) begin n_fail++; $display("FAIL narrow_neg: got y=%h ovf=%0b cnt=%0d want 800/0/0", o_y, o_ovf, o_ovf_cnt); end
        i_x = 32'h0000_0800;
        tick();
`ifdef SIGN_NARROW_SAT_EN
        exp_y = 12'h7FF;
`else
        exp_y = 12'h800;
`endif
        n_checks++; if (o_y !== exp_y || o_ovf !== 1'b1) begin n_fail++; $display("FAIL narrow_ovf_pos: got y=%h ovf=%0b want %h/1", o_y, o_ovf, exp_y); end
        n_checks++; if (o_ovf_sticky !== 1'b1 || o_ovf_cnt !== 4'd1) begin n_fail++; $display("FAIL narrow_stats1: got %0b/%0d want 1/1", o_ovf_sticky, o_ovf_cnt); end
        i_x = 32'h8000_0000;
        tick();
`ifdef SIGN_NARROW_SAT_EN
        exp_y = 12'h800;
`else
        exp_y = 12'h000;
`endif
        n_checks++; if (o_y !== exp_y || o_ovf !== 1'b1 || o_ovf_cnt !== 4'd2) begin n_fail++; $display("FAIL narrow_ovf_neg: got y=%h ovf=%0b cnt=%0d want %h/1/2", o_y, o_ovf, o_ovf_cnt, exp_y); end
        i_valid = 1'b0;
        tick();
        n_checks++; if (o_valid !== 1'b0 || o_ovf_cnt !== 4'd2) begin n_fail++; $display("FAIL narrow_idle: got v=%0b cnt=%0d want 0/2", o_valid, o_ovf_cnt); end
    endtask

    task automatic test_clear();
        i_clr = 1'b1; i_valid = 1'b1; i_x = 32'h0000_0800;
        tick();
        n_checks++; if (o_ovf_cnt !== 4'd1 || o_ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL clr_with_ovf: got %0b/%0d want 1/1", o_ovf_sticky, o_ovf_cnt); end
        i_valid = 1'b0;
        tick();
        n_checks++; if (o_ovf_cnt !== 4'd0 || o_ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL clr_alone: got %0b/%0d want 0/0", o_ovf_sticky, o_ovf_cnt); end
        i_clr = 1'b0;
        i_x = 32'h0000_0800;
        tick(); tick();
        n_checks++; if (o_ovf_cnt !== 4'd0) begin n_fail++; $display("FAIL idle_no_count: got %0d want 0", o_ovf_cnt); end
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0; i_valid = 1'b1; i_x = 32'd1;
        tick();
        n_checks++; if (o_valid !== 1'b1 || o_y !== 12'd1 || o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first: got v=%0b y=%h r=%0b want 1/001/1", o_valid, o_y, o_ready); end
        i_x = 32'd2;
        tick();
        n_checks++; if (o_ready !== 1'b0 || o_y !== 12'd1) begin n_fail++; $display("FAIL bp_full: got r=%0b y=%h want 0/001", o_ready, o_y); end
        i_x = 32'd3;
        tick(); tick();
        n_checks++; if (o_ready !== 1'b0 || o_y !== 12'd1 || o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got r=%0b y=%h v=%0b want 0/001/1", o_ready, o_y, o_valid); end
        i_ready = 1'b1;
        tick();
        n_checks++; if (o_y !== 12'd2 || o_ready !== 1'b1) begin n_fail++; $display("FAIL bp_out2: got y=%h r=%0b want 002/1", o_y, o_ready); end
        tick();
        n_checks++; if (o_y !== 12'd3 || o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out3: got y=%h v=%0b want 003/1", o_y, o_valid); end
        i_valid = 1'b0;
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got v=%0b want 0", o_valid); end
    endtask

    task automatic test_stream();
        logic [N:0] q[$];
        logic [N:0] exp_beat;
        logic [31:0] r;
        int n_ovf;
        i_clr = 1'b1; i_valid = 1'b0;
        tick();
        i_clr = 1'b0;
        n_ovf = 0;
        for (int i = 0; i < 1000; i++) begin
            r = $urandom;
            i_valid = r[0];
            i_ready = (r[3:1] != 3'd0);
            if (i_valid) begin
                i_x = r[4] ? $urandom : {{(M-N){r[31]}}, r[31:20]};
            end else begin
                i_x = 'x;
            end
            if (o_valid && i_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra: got y=%h with no beat expected", o_y);
                end else begin
                    exp_beat = q.pop_front();
                    if ({o_ovf, o_y} !== exp_beat) begin n_fail++; $display("FAIL stream_beat: got ovf=%0b y=%h want %0b/%h", o_ovf, o_y, exp_beat[N], exp_beat[N-1:0]); end
                end
            end
            if (i_valid && o_ready) begin
                q.push_back({model_ovf(i_x), model_y(i_x)});
                if (model_ovf(i_x)) n_ovf++;
            end
            tick();
        end
        i_valid = 1'b0; i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (o_valid) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL drain_extra: got y=%h with no beat expected", o_y);
                end else begin
                    exp_beat = q.pop_front();
                    if ({o_ovf, o_y} !== exp_beat) begin n_fail++; $display("FAIL drain_beat: got ovf=%0b y=%h want %0b/%h", o_ovf, o_y, exp_beat[N], exp_beat[N-1:0]); end
                end
            end
            tick();
        end
        n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL stream_lost: got %0d beats missing want 0", q.size()); end
        n_checks++; if (int'(o_ovf_cnt) != ((n_ovf > c_cnt_max) ? c_cnt_max : n_ovf)) begin n_fail++; $display("FAIL stream_cnt: got %0d want %0d", o_ovf_cnt, (n_ovf > c_cnt_max) ? c_cnt_max : n_ovf); end
        n_checks++; if (o_ovf_sticky !== (n_ovf > 0)) begin n_fail++; $display("FAIL stream_sticky: got %0b want %0b", o_ovf_sticky, n_ovf > 0); end
    endtask

    task automatic test_reset_midstream();
        i_ready = 1'b0; i_valid = 1'b1; i_x = 32'h0001_0000;
        tick();
        i_x = 32'd9;
        tick();
        n_checks++; if (o_ready !== 1'b0 || o_ovf_cnt === 4'd0) begin n_fail++; $display("FAIL mid_setup: got r=%0b cnt=%0d want 0/nonzero", o_ready, o_ovf_cnt); end
        rst = 1'b1; i_valid = 1'b0;
        tick();
        n_checks++; if (o_valid !== 1'b0 || o_ovf_cnt !== 4'd0 || o_ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got v=%0b cnt=%0d sticky=%0b want 0/0/0", o_valid, o_ovf_cnt, o_ovf_sticky); end
        rst = 1'b0; i_ready = 1'b1;
        tick();
        i_valid = 1'b1; i_x = 32'h0000_0005;
        tick();
        n_checks++; if (o_valid !== 1'b1 || o_y !== 12'h005 || o_ovf !== 1'b0) begin n_fail++; $display("FAIL mid_first: got v=%0b y=%h ovf=%0b want 1/005/0", o_valid, o_y, o_ovf); end
        i_valid = 1'b0;
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_dup: got v=%0b want 0", o_valid); end
    endtask

    initial begin
        test_reset();
        test_narrow();
        test_clear();
        test_backpressure();
        test_stream();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
